elastic_pipe: RTL and testbench
===============================

Name: elastic_pipe

Overview:
- Parametrised successor to the single-entry valid/ready pipeline register: a DEPTH-entry elastic buffer between RV32I pipeline stages.
- ready_out is a pure function of local state and has no combinational path from ready_in. This breaks long ready chains across stages.
- Sustains one transfer per cycle for DEPTH>=2. Supports flush and synchronous reset for branch/exception squashing.

Parameters:
- T, logic [31:0], payload type carried per entry.
- DEPTH, 2, number of storage entries; legal range 1..16; need not be a power of two.
- CNT_W, $clog2(DEPTH+1), width of occupancy output (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- async_rst_n  input  1  asynchronous active-low reset.
- sync_rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous discard of all buffered entries.
- valid_in  input  1  producer offers d.
- d  input  $bits(T)  producer payload.
- ready_out  output  1  buffer can accept an entry this cycle.
- valid_out  output  1  q holds a valid entry.
- q  output  $bits(T)  head-of-buffer payload.
- ready_in  input  1  consumer accepts q this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array mem[0..DEPTH-1], rd_ptr, wr_ptr, count register.
- Reset, async or sync: count=0, rd_ptr=0, wr_ptr=0, so valid_out=0, ready_out=1, q='0. Storage contents need not be reset.
- Priority: async_rst_n > sync_rst_n > flush > normal operation.
- ready_out = (count != DEPTH). Must not depend on ready_in, valid_in or d.
- valid_out = (count != 0).
- q = valid_out ? mem[rd_ptr] : '0. q is never X when empty.
- push = valid_in && ready_out. On the clock edge, mem[wr_ptr] <= d and wr_ptr advances.
- pop = valid_out && ready_in. On the clock edge, rd_ptr advances.
- Count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Pointer wrap: after DEPTH-1 the next value is 0. Non-power-of-two DEPTH wraps explicitly; no reliance on natural overflow.
- Latency: an entry pushed at edge N is visible on q/valid_out after edge N. Minimum 1-cycle latency; no combinational d->q bypass.
- Full: ready_out=0. A simultaneous pop frees a slot, but ready_out rises only in the next cycle. Any valid_in held that cycle is not accepted.
- Empty: valid_out=0. A pop is impossible; ready_in is ignored.
- Throughput: DEPTH>=2 sustains 1 transfer/cycle with ready_in held high. DEPTH=1 alternates accept/drain and gives 50% throughput.
- Flush: on the next edge, count, rd_ptr and wr_ptr all become 0. A push or pop in the same cycle is discarded and not counted. ready_out=1 and valid_out=0 in the following cycle.
- sync_rst_n low mid-stream behaves identically to flush.
- Async reset mid-transfer: outputs go to reset values immediately, independent of clk.
- Order: strict FIFO; no entry is duplicated or dropped except by flush or reset.

Optional Feature:
- Macro: ELASTIC_PIPE_STALL_CNT_EN.
- With the macro defined:
  - Extra output port stall_cnt, 16 bits.
  - Increments each cycle where valid_out && !ready_in (backpressure stall). Saturates at 16'hFFFF.
  - Cleared by async reset, sync_rst_n and flush.
- Without the macro: the port and its logic are absent. The core interface and behaviour are unchanged.

Test Plan:
- Reset: assert async_rst_n=0 mid-cycle with count=2 -> immediately valid_out=0, ready_out=1, q=0, count=0.
- Streaming, DEPTH=2: push 0x11,0x22,0x33,0x44 on consecutive cycles with ready_in=1 -> q shows 0x11..0x44 on consecutive cycles one cycle later; ready_out stays 1.
- Fill and backpressure, DEPTH=3:
  - With ready_in=0, push 0xA,0xB,0xC -> count=3, ready_out=0.
  - A 4th valid_in of 0xD is not accepted.
  - Raise ready_in -> outputs 0xA,0xB,0xC in order.
  - 0xD is accepted only after ready_out returns to 1.
- Full with simultaneous pop, DEPTH=2, count=2:
  - Set ready_in=1 and valid_in=1 with d=0x55 -> 0x55 is not accepted that cycle; count=1 next cycle; ready_out=1.
- Flush: with count=2, assert flush together with valid_in=1 (d=0x77) and ready_in=1 -> next cycle count=0, valid_out=0. 0x77 never appears on q.
- Stall counter, ELASTIC_PIPE_STALL_CNT_EN defined: hold valid_out=1, ready_in=0 for 5 cycles -> stall_cnt=5. Then assert flush -> stall_cnt=0.

Source files
------------

// File: rtl/elastic_pipe.sv
// Parametrised DEPTH-entry elastic buffer between pipeline stages; ready_out depends on local state only.
// Optional backpressure stall counter enabled by defining ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe #(
  parameter type             T     = logic [31:0],
  parameter int unsigned     DEPTH = 2,
  localparam int unsigned    CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             sync_rst_n,
  input  logic             flush,
  input  logic             valid_in,
  input  T                 d,
  output logic             ready_out,
  output logic             valid_out,
  output T                 q,
  input  logic             ready_in,
`ifdef ELASTIC_PIPE_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, clear, mem_we;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ready_out = (count_q != FullCnt);
    valid_out = (count_q != '0);
    push      = valid_in && ready_out;
    pop       = valid_out && ready_in;
    clear     = !sync_rst_n || flush;
    mem_we    = push && !clear;
    q         = valid_out ? mem_q[rd_ptr_q] : '0;
    count     = count_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; q is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= d;
  end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear) begin
      stall_cnt_d = '0;
    end else if (valid_out && !ready_in && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) stall_cnt_q <= '0;
    else              stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  a_count_range: assert property (@(posedge clk) disable iff (!async_rst_n)
    count_q <= FullCnt);
  a_ptr_range: assert property (@(posedge clk) disable iff (!async_rst_n)
    (rd_ptr_q <= LastPtr) && (wr_ptr_q <= LastPtr));

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: DEPTH=2 and DEPTH=3 instances share stimulus, each checked against a
// queue model every cycle, plus directed literal expectations.
module tb_elastic_pipe;

  logic        clk = 1'b0;
  logic        async_rst_n, sync_rst_n, flush, valid_in, ready_in;
  logic [31:0] d;
  logic        rdy2, vld2, rdy3, vld3;
  logic [31:0] q2, q3;
  logic [1:0]  cnt2, cnt3;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
  logic [15:0] st2, st3;
`endif

  int checks = 0;
  int errors = 0;

  elastic_pipe #(.DEPTH(2)) u_dut2 (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .sync_rst_n (sync_rst_n),
    .flush      (flush),
    .valid_in   (valid_in),
    .d          (d),
    .ready_out  (rdy2),
    .valid_out  (vld2),
    .q          (q2),
    .ready_in   (ready_in),
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    .stall_cnt  (st2),
`endif
    .count      (cnt2)
  );

  elastic_pipe #(.DEPTH(3)) u_dut3 (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .sync_rst_n (sync_rst_n),
    .flush      (flush),
    .valid_in   (valid_in),
    .d          (d),
    .ready_out  (rdy3),
    .valid_out  (vld3),
    .q          (q3),
    .ready_in   (ready_in),
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    .stall_cnt  (st3),
`endif
    .count      (cnt3)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each buffer is a FIFO queue bounded by its depth.
  logic [31:0] m2[$];
  logic [31:0] m3[$];
  int          ms2, ms3;
  bit          v2, v3, r2, r3;

  always @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      m2.delete(); m3.delete();
      ms2 = 0; ms3 = 0;
    end else begin
      v2 = m2.size() != 0; r2 = m2.size() != 2;
      v3 = m3.size() != 0; r3 = m3.size() != 3;
      if (!sync_rst_n || flush) begin
        m2.delete(); m3.delete();
        ms2 = 0; ms3 = 0;
      end else begin
        if (v2 && !ready_in && ms2 != 65535) ms2++;
        if (v3 && !ready_in && ms3 != 65535) ms3++;
        if (v2 && ready_in) void'(m2.pop_front());
        if (v3 && ready_in) void'(m3.pop_front());
        if (valid_in && r2) m2.push_back(d);
        if (valid_in && r3) m3.push_back(d);
      end
    end
  end

  always @(negedge clk) begin
    chk("d2_valid", {31'd0, vld2}, {31'd0, m2.size() != 0});
    chk("d2_ready", {31'd0, rdy2}, {31'd0, m2.size() != 2});
    chk("d2_q", q2, (m2.size() != 0) ? m2[0] : 32'h0);
    chk("d2_count", {30'd0, cnt2}, m2.size());
    chk("d3_valid", {31'd0, vld3}, {31'd0, m3.size() != 0});
    chk("d3_ready", {31'd0, rdy3}, {31'd0, m3.size() != 3});
    chk("d3_q", q3, (m3.size() != 0) ? m3[0] : 32'h0);
    chk("d3_count", {30'd0, cnt3}, m3.size());
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    chk("d2_stall", {16'd0, st2}, ms2);
    chk("d3_stall", {16'd0, st3}, ms3);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    async_rst_n = 1'b0; sync_rst_n = 1'b1; flush = 1'b0;
    valid_in = 1'b0; ready_in = 1'b0; d = '0;
    tick(); tick();
    async_rst_n = 1'b1;
    chk("rst_valid", {31'd0, vld2}, 32'd0);
    chk("rst_ready", {31'd0, rdy2}, 32'd1);
    chk("rst_q", q2, 32'd0);
    chk("rst_count", {30'd0, cnt3}, 32'd0);

    // Streaming through DEPTH=2
    ready_in = 1'b1; valid_in = 1'b1;
    d = 32'h11; tick();
    chk("stream_q11", q2, 32'h11); chk("stream_rdy", {31'd0, rdy2}, 32'd1);
    d = 32'h22; tick();
    chk("stream_q22", q2, 32'h22); chk("stream_rdy", {31'd0, rdy2}, 32'd1);
    d = 32'h33; tick();
    chk("stream_q33", q2, 32'h33); chk("stream_rdy", {31'd0, rdy2}, 32'd1);
    d = 32'h44; tick();
    chk("stream_q44", q2, 32'h44); chk("stream_rdy", {31'd0, rdy2}, 32'd1);
    valid_in = 1'b0; tick();
    chk("stream_empty", {31'd0, vld2}, 32'd0);
    drain();

    // Fill and backpressure on DEPTH=3
    ready_in = 1'b0; valid_in = 1'b1;
    d = 32'hA; tick();
    d = 32'hB; tick();
    d = 32'hC; tick();
    chk("fill_count", {30'd0, cnt3}, 32'd3);
    chk("fill_ready", {31'd0, rdy3}, 32'd0);
    d = 32'hD; tick();
    chk("fill_rejectD", {30'd0, cnt3}, 32'd3);
    chk("fill_headA", q3, 32'hA);
    ready_in = 1'b1; tick();
    chk("bp_qB", q3, 32'hB); chk("bp_count2", {30'd0, cnt3}, 32'd2);
    chk("bp_ready", {31'd0, rdy3}, 32'd1);
    tick();
    chk("bp_qC", q3, 32'hC); chk("bp_acceptD", {30'd0, cnt3}, 32'd2);
    valid_in = 1'b0; tick();
    chk("bp_qD", q3, 32'hD); chk("bp_count1", {30'd0, cnt3}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, vld3}, 32'd0);
    drain();

    // Full with simultaneous pop on DEPTH=2
    ready_in = 1'b0; valid_in = 1'b1;
    d = 32'h1; tick();
    d = 32'h2; tick();
    chk("full_count", {30'd0, cnt2}, 32'd2);
    ready_in = 1'b1; d = 32'h55; tick();
    chk("fullpop_count", {30'd0, cnt2}, 32'd1);
    chk("fullpop_ready", {31'd0, rdy2}, 32'd1);
    chk("fullpop_q", q2, 32'h2);
    valid_in = 1'b0; tick();
    chk("fullpop_no55", {31'd0, vld2}, 32'd0);
    drain();

    // Flush with concurrent push and pop
    ready_in = 1'b0; valid_in = 1'b1;
    d = 32'h1; tick();
    d = 32'h2; tick();
    flush = 1'b1; ready_in = 1'b1; d = 32'h77; tick();
    chk("flush_count", {30'd0, cnt2}, 32'd0);
    chk("flush_valid", {31'd0, vld2}, 32'd0);
    chk("flush_ready", {31'd0, rdy2}, 32'd1);
    chk("flush_count3", {30'd0, cnt3}, 32'd0);
    flush = 1'b0; valid_in = 1'b0; tick();
    chk("flush_no77", {31'd0, vld2}, 32'd0);

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    ready_in = 1'b0; valid_in = 1'b1; d = 32'h9; tick();
    valid_in = 1'b0;
    repeat (5) tick();
    chk("stall_five", {16'd0, st2}, 32'd5);
    flush = 1'b1; tick();
    chk("stall_flush", {16'd0, st2}, 32'd0);
    flush = 1'b0;
`endif
    drain();

    // Asynchronous reset between edges
    ready_in = 1'b0; valid_in = 1'b1;
    d = 32'h3; tick();
    d = 32'h4; tick();
    chk("arst_pre", {30'd0, cnt2}, 32'd2);
    valid_in = 1'b0;
    #1 async_rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, vld2}, 32'd0);
    chk("arst_ready", {31'd0, rdy2}, 32'd1);
    chk("arst_q", q2, 32'd0);
    chk("arst_count", {30'd0, cnt2}, 32'd0);
    tick();
    async_rst_n = 1'b1;

    // Synchronous reset mid-stream
    valid_in = 1'b1; d = 32'h5; tick(); tick();
    sync_rst_n = 1'b0; tick();
    chk("srst_count", {30'd0, cnt3}, 32'd0);
    sync_rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      valid_in   = $urandom_range(0, 3) != 0;
      d          = $urandom;
      ready_in   = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 3) != 0);
      flush      = $urandom_range(0, 39) == 0;
      sync_rst_n = $urandom_range(0, 59) != 0;
      tick();
    end
    flush = 1'b0; sync_rst_n = 1'b1; valid_in = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
